// File: rtl/msg_gt_checker_pkg.sv
// Shared definitions for the message checker: operator codes, error codes,
// FSM encodings and the redundancy function used by the message network.
package msg_gt_checker_pkg;

  localparam int NS_ADDRESS_SIZE = 6;
  localparam int NS_DATA_SIZE    = 8;
  localparam int NS_REDUN_SIZE   = 4;

  localparam logic [1:0] NS_GT_OP = 2'd1;
  localparam logic [1:0] NS_LT_OP = 2'd2;
  localparam logic [1:0] NS_EQ_OP = 2'd3;

  localparam logic [3:0] ERR_NONE  = 4'd0;
  localparam logic [3:0] ERR_OP    = 4'd1;
  localparam logic [3:0] ERR_RED   = 4'd2;
  localparam logic [3:0] ERR_SEQ   = 4'd3;
  localparam logic [3:0] ERR_RANGE = 4'd4;

  localparam logic [1:0] ST_WAIT  = 2'd0;
  localparam logic [1:0] ST_CHECK = 2'd1;
  localparam logic [1:0] ST_ACK   = 2'd2;

  // Caller truncates the sum to its redundancy width.
  function automatic logic [31:0] ns_calc_redun(input logic [31:0] addr,
                                                input logic [31:0] dat);
    return addr + dat;
  endfunction

endpackage

// File: rtl/msg_gt_checker_sync2.sv
// Two-flop synchronizer for a single-bit level crossing into i_clk.
module ns_sync2 (
  input  logic i_clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic s1;

  // Shift the asynchronous level through two flops.
  always_ff @(posedge i_clk) begin
    if (reset) begin
      s1 <= 1'b0;
      q  <= 1'b0;
    end else begin
      s1 <= d;
      q  <= s1;
    end
  end

endmodule

// File: rtl/msg_gt_checker.sv
// Terminal sink behind a filter node: consumes 2-phase messages, checks the
// address against the filter rule, the redundancy field and the wrap-around
// address sequence, and exposes count and first error on debug outputs.
module msg_gt_checker
  import msg_gt_checker_pkg::*;
#(
  parameter int         ASZ       = NS_ADDRESS_SIZE,
  parameter int         DSZ       = NS_DATA_SIZE,
  parameter int         RSZ       = NS_REDUN_SIZE,
  parameter int         MIN_ADDR  = 0,
  parameter int         MAX_ADDR  = 55,
  parameter logic [1:0] OPER_1    = NS_GT_OP,
  parameter int         REF_VAL_1 = 23,
  parameter int         CNT_SZ    = 16
) (
  input  logic           i_clk,
  input  logic           reset,
  input  logic [ASZ-1:0] i0_addr,
  input  logic [DSZ-1:0] i0_dat,
  input  logic [RSZ-1:0] i0_red,
  input  logic           i0_req,
  output logic           i0_ack,
  output logic [3:0]     dbg_leds,
  output logic [3:0]     dbg_disp0,
  output logic [3:0]     dbg_disp1
);

  localparam bit OP_VALID = (OPER_1 == NS_GT_OP) || (OPER_1 == NS_LT_OP) ||
                            (OPER_1 == NS_EQ_OP);
  localparam int FIRST_OK = (OPER_1 == NS_GT_OP) ? REF_VAL_1 + 1 :
                            (OPER_1 == NS_LT_OP) ? MIN_ADDR : REF_VAL_1;
  localparam int LAST_OK  = (OPER_1 == NS_GT_OP) ? MAX_ADDR :
                            (OPER_1 == NS_LT_OP) ? REF_VAL_1 - 1 : REF_VAL_1;

  logic              rq_s2;
  logic [1:0]        state_q, state_d;
  logic              ack_q, ack_d;
  logic [CNT_SZ-1:0] cnt_q, cnt_d;
  logic [3:0]        err_q, err_d;
  logic [ASZ-1:0]    last_addr_q, last_addr_d;
  logic              seen_q, seen_d;
  logic              tog_q, tog_d;

  logic              pending;
  logic              op_ok, red_ok, seq_ok, range_bad;
  logic [3:0]        code;
  int                addr_i, last_i;

  ns_sync2 u_req_sync (
    .i_clk (i_clk),
    .reset (reset),
    .d     (i0_req),
    .q     (rq_s2)
  );

  assign pending = rq_s2 != ack_q;

  // Message checks; inputs are stable for the whole handshake.
  always_comb begin
    addr_i    = int'(i0_addr);
    last_i    = int'(last_addr_q);
    range_bad = (addr_i < MIN_ADDR) || (addr_i > MAX_ADDR);
    op_ok     = 1'b1;
    if (OPER_1 == NS_GT_OP) op_ok = addr_i > REF_VAL_1;
    if (OPER_1 == NS_LT_OP) op_ok = addr_i < REF_VAL_1;
    if (OPER_1 == NS_EQ_OP) op_ok = addr_i == REF_VAL_1;
    red_ok = i0_red == RSZ'(ns_calc_redun(32'(i0_addr), 32'(i0_dat)));
    seq_ok = !seen_q || (addr_i == last_i + 1) ||
             ((last_i == LAST_OK) && (addr_i == FIRST_OK));
    if (range_bad)                code = ERR_RANGE;
    else if (OP_VALID && !op_ok)  code = ERR_OP;
    else if (!red_ok)             code = ERR_RED;
    else if (OP_VALID && !seq_ok) code = ERR_SEQ;
    else                          code = ERR_NONE;
  end

  // FSM and tracking-register next state; ack toggles on leaving ST_CHECK.
  always_comb begin
    state_d     = state_q;
    ack_d       = ack_q;
    cnt_d       = cnt_q;
    err_d       = err_q;
    last_addr_d = last_addr_q;
    seen_d      = seen_q;
    tog_d       = tog_q;
    case (state_q)
      ST_WAIT: begin
        if (pending) state_d = ST_CHECK;
      end
      ST_CHECK: begin
        last_addr_d = i0_addr;
        seen_d      = 1'b1;
        tog_d       = ~tog_q;
        if (!(&cnt_q))          cnt_d = cnt_q + 1'b1;
        if (err_q == ERR_NONE)  err_d = code;
        ack_d       = ~ack_q;
        state_d     = ST_ACK;
      end
      ST_ACK: begin
        state_d = ST_WAIT;
      end
      default: state_d = ST_WAIT;
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge i_clk) begin
    if (reset) begin
      state_q     <= ST_WAIT;
      ack_q       <= 1'b0;
      cnt_q       <= '0;
      err_q       <= ERR_NONE;
      last_addr_q <= '0;
      seen_q      <= 1'b0;
      tog_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      ack_q       <= ack_d;
      cnt_q       <= cnt_d;
      err_q       <= err_d;
      last_addr_q <= last_addr_d;
      seen_q      <= seen_d;
      tog_q       <= tog_d;
    end
  end

  // Debug outputs derived from the registered state.
  always_comb begin
    i0_ack    = ack_q;
    dbg_leds  = {&cnt_q, seen_q, tog_q, err_q != ERR_NONE};
    dbg_disp0 = cnt_q[3:0];
    dbg_disp1 = (err_q != ERR_NONE) ? err_q : cnt_q[7:4];
  end

endmodule

// File: tb/tb_msg_gt_checker.sv
// Scoreboard bench for msg_gt_checker with GT operator, REF 23, range 0..55.
module tb_msg_gt_checker;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] addr;
  logic [7:0] dat;
  logic [3:0] red;
  logic       req;
  logic       ack;
  logic [3:0] leds, d0, d1;

  int checks   = 0;
  int failures = 0;
  int acks     = 0;

  bit  m_seen;
  int  m_last;
  int  m_err;
  int  m_cnt;
  bit  m_tog;
  logic [11:0] exp_q[$];

  always #5 clk = ~clk;

  msg_gt_checker dut (
    .i_clk     (clk),
    .reset     (reset),
    .i0_addr   (addr),
    .i0_dat    (dat),
    .i0_red    (red),
    .i0_req    (req),
    .i0_ack    (ack),
    .dbg_leds  (leds),
    .dbg_disp0 (d0),
    .dbg_disp1 (d1)
  );

  task automatic model_reset();
    m_seen = 0;
    m_last = 0;
    m_err  = 0;
    m_cnt  = 0;
    m_tog  = 0;
    acks   = 0;
    exp_q.delete();
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset = 1'b1;
    req   = 1'b0;
    addr  = '0;
    dat   = '0;
    red   = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    checks++;
    if (ack !== 1'b0) begin
      failures++;
      $display("FAIL reset_ack got=%b want=0", ack);
    end
    checks++;
    if ({leds, d1, d0} !== 12'h000) begin
      failures++;
      $display("FAIL reset_dbg got=%h want=000", {leds, d1, d0});
    end
  endtask

  // Drive one message, push the model's expected debug state, then compare on ack.
  task automatic send(input int a, input bit bad_red);
    int d, code, lat;
    logic [11:0] e, got;
    logic [3:0] ec, cc;
    @(negedge clk);
    d    = $urandom_range(0, 255);
    addr = 6'(a);
    dat  = 8'(d);
    red  = 4'((a + d + int'(bad_red)) % 16);
    req  = ~req;
    if (a > 55)          code = 4;
    else if (a <= 23)    code = 1;
    else if (bad_red)    code = 2;
    else if (m_seen && !(a == m_last + 1 || (m_last == 55 && a == 24))) code = 3;
    else                 code = 0;
    if (m_err == 0) m_err = code;
    m_last = a;
    m_seen = 1;
    if (m_cnt < 65535) m_cnt++;
    m_tog = ~m_tog;
    ec = 4'(m_err);
    cc = 4'(m_cnt >> 4);
    e = {(m_cnt == 65535), m_seen, m_tog, (m_err != 0),
         (m_err != 0) ? ec : cc, 4'(m_cnt)};
    exp_q.push_back(e);
    lat = 0;
    while (ack !== req && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    if (ack === req) acks++;
    checks++;
    if (lat != 4) begin
      failures++;
      $display("FAIL latency addr=%0d got=%0d want=4", a, lat);
    end
    got = {leds, d1, d0};
    checks++;
    if (exp_q.size() == 0) begin
      failures++;
      $display("FAIL scoreboard_empty addr=%0d got=%h", a, got);
    end else begin
      e = exp_q.pop_front();
      if (got !== e) begin
        failures++;
        $display("FAIL dbg addr=%0d got=%h want=%h", a, got, e);
      end
    end
  endtask

  task automatic test_stream();
    test_reset();
    for (int a = 24; a <= 55; a++) send(a, 1'b0);
    checks++;
    if (acks != 32) begin
      failures++;
      $display("FAIL ack_count got=%0d want=32", acks);
    end
    checks++;
    if (d0 !== 4'd0 || d1 !== 4'd2 || leds[0] !== 1'b0) begin
      failures++;
      $display("FAIL stream_disp got=%h/%h/%b want=0/2/0", d0, d1, leds[0]);
    end
  endtask

  task automatic test_wrap();
    send(24, 1'b0);
    send(25, 1'b0);
    send(26, 1'b0);
    checks++;
    if (d0 !== 4'd3 || d1 !== 4'd2 || leds[0] !== 1'b0) begin
      failures++;
      $display("FAIL wrap_count got=%h/%h/%b want=3/2/0", d0, d1, leds[0]);
    end
  endtask

  task automatic test_op_err();
    send(20, 1'b0);
    checks++;
    if (d1 !== 4'd1 || leds[0] !== 1'b1) begin
      failures++;
      $display("FAIL op_err got=%h/%b want=1/1", d1, leds[0]);
    end
    send(27, 1'b0);
  endtask

  task automatic test_red_err();
    test_reset();
    send(30, 1'b1);
    send(40, 1'b0);
    checks++;
    if (d1 !== 4'd2) begin
      failures++;
      $display("FAIL red_sticky got=%h want=2", d1);
    end
  endtask

  task automatic test_seq_err();
    test_reset();
    send(24, 1'b0);
    send(25, 1'b0);
    checks++;
    if (leds[0] !== 1'b0) begin
      failures++;
      $display("FAIL seq_early got=%b want=0", leds[0]);
    end
    send(27, 1'b0);
    checks++;
    if (d1 !== 4'd3) begin
      failures++;
      $display("FAIL seq_err got=%h want=3", d1);
    end
    send(60, 1'b0);
  endtask

  task automatic test_reset_mid();
    test_reset();
    @(negedge clk);
    addr = 6'd24;
    dat  = 8'd0;
    red  = 4'd8;
    req  = ~req;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    req   = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    checks++;
    if (ack !== 1'b0 || d0 !== 4'd0 || leds !== 4'd0) begin
      failures++;
      $display("FAIL reset_mid got=%b/%h/%h want=0/0/0", ack, d0, leds);
    end
    send(40, 1'b0);
    checks++;
    if (d0 !== 4'd1) begin
      failures++;
      $display("FAIL after_reset_count got=%h want=1", d0);
    end
  endtask

  initial begin
    reset = 1'b1;
    req   = 1'b0;
    addr  = '0;
    dat   = '0;
    red   = '0;
    test_stream();
    test_wrap();
    test_op_err();
    test_red_err();
    test_seq_err();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
